page_stream_scatter_q: RTL

PAGE_STREAM_SCATTER_Q -- requirements
Module: page_stream_scatter_q

---
 rtl/page_stream_scatter_q.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/page_stream_scatter_q.sv
// page_stream_scatter_q: scatters an input token stream round-robin over N
// per-channel FIFOs, BLOCK tokens per channel before advancing. An EOS token
// is broadcast atomically to every channel and restarts the rotation at 0.
// With DRAIN_ON_EOS=1 the input stalls after an EOS until every queue empties.
//
// Handshake: a transfer happens on a rising edge exactly when valid=1 and the
// matching back-pressure (in_b / out_b[k]) is 0 in that cycle; back-pressure
// is the inverse of ready. in_b depends combinationally on in_e because a
// data token needs only its target queue while an EOS needs all of them.
module page_stream_scatter_q #(
   parameter int W            = 16,
   parameter int N            = 8,
   parameter int DEPTH        = 4,
   parameter int BLOCK        = 1,
   parameter int DRAIN_ON_EOS = 0
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [W-1:0]           in_d,
   input  logic                   in_e,
   input  logic                   in_v,
   output logic                   in_b,
   output logic [N*W-1:0]         out_d,
   output logic [N-1:0]           out_e,
   output logic [N-1:0]           out_v,
   input  logic [N-1:0]           out_b,
   output logic                   dbgState,   // 0 = RUN, 1 = DRAIN
   output logic [$clog2(N)-1:0]   dbgChIdx    // current write target channel
);

   localparam int CW   = $clog2(N);
   localparam int PW   = $clog2(DEPTH);
   localparam int CNTW = $clog2(DEPTH + 1);
   localparam int BW   = (BLOCK > 1) ? $clog2(BLOCK) : 1;

   typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} stateT;

   stateT            state, nextState;
   logic [CW-1:0]    chIdx;
   logic [BW-1:0]    blkCnt;
   logic [W:0]       mem [N][DEPTH];
   logic [PW-1:0]    rdPtr [N];
   logic [PW-1:0]    wrPtr [N];
   logic [CNTW-1:0]  cnt [N];
   logic [N-1:0]     full;
   logic [N-1:0]     push;
   logic [N-1:0]     pop;
   logic             accept;
   logic             allEmptyNext;

   assign dbgState = state;
   assign dbgChIdx = chIdx;

   // Queue status, heads, back-pressure and per-channel push/pop strobes.
   always_comb begin
      full  = '0;
      push  = '0;
      pop   = '0;
      out_v = '0;
      out_e = '0;
      out_d = '0;
      for (int k = 0; k < N; k++) begin
         full[k]  = (cnt[k] == CNTW'(DEPTH));
         out_v[k] = (cnt[k] != '0) && !reset;
         if (out_v[k]) begin
            out_d[k*W +: W] = mem[k][rdPtr[k]][W-1:0];
            out_e[k]        = mem[k][rdPtr[k]][W];
         end
         pop[k] = out_v[k] && !out_b[k];
      end
      // Full is judged before any same-cycle pop, so push-on-full never occurs.
      in_b   = reset || (state == DRAIN) || (in_e ? (|full) : full[chIdx]);
      accept = in_v && !in_b;
      for (int k = 0; k < N; k++) begin
         push[k] = accept && (in_e || (chIdx == CW'(k)));
      end
   end

   // True when every queue will be empty after this edge's pops.
   always_comb begin
      allEmptyNext = 1'b1;
      for (int k = 0; k < N; k++) begin
         if (!((cnt[k] == '0) || ((cnt[k] == CNTW'(1)) && pop[k]))) begin
            allEmptyNext = 1'b0;
         end
      end
   end

   // Next-state logic for the RUN/DRAIN machine.
   always_comb begin
      nextState = state;
      case (state)
         RUN:     if (accept && in_e && (DRAIN_ON_EOS != 0)) nextState = DRAIN;
         DRAIN:   if (allEmptyNext) nextState = RUN;
         default: nextState = RUN;
      endcase
   end

   // State register.
   always_ff @(posedge clock) begin
      if (reset) state <= RUN;
      else       state <= nextState;
   end

   // Round-robin target channel and block counter; EOS restarts at channel 0.
   always_ff @(posedge clock) begin
      if (reset) begin
         chIdx  <= '0;
         blkCnt <= '0;
      end else if (accept) begin
         if (in_e) begin
            chIdx  <= '0;
            blkCnt <= '0;
         end else if (blkCnt == BW'(BLOCK - 1)) begin
            blkCnt <= '0;
            chIdx  <= (chIdx == CW'(N - 1)) ? '0 : chIdx + 1'b1;
         end else begin
            blkCnt <= blkCnt + 1'b1;
         end
      end
   end

   // Queue storage; contents need no reset because heads are masked by valid.
   always_ff @(posedge clock) begin
      for (int k = 0; k < N; k++) begin
         if (push[k]) mem[k][wrPtr[k]] <= {in_e, in_d};
      end
   end

   // Queue pointers and occupancy counts.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int k = 0; k < N; k++) begin
            rdPtr[k] <= '0;
            wrPtr[k] <= '0;
            cnt[k]   <= '0;
         end
      end else begin
         for (int k = 0; k < N; k++) begin
            if (push[k]) wrPtr[k] <= wrPtr[k] + 1'b1;
            if (pop[k])  rdPtr[k] <= rdPtr[k] + 1'b1;
            if (push[k] && !pop[k])      cnt[k] <= cnt[k] + 1'b1;
            else if (pop[k] && !push[k]) cnt[k] <= cnt[k] - 1'b1;
         end
      end
   end

endmodule
